// File: rtl/apb_request_master_pkg.sv
// rtl/apb_request_master_pkg.sv - shared FSM state and APB bundle types for the request master
package apb_request_master_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] paddr;
    logic              penable;
    logic              psel;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
  } apb_request_t;

  typedef struct packed {
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              perr;
  } apb_response_t;

endpackage

// File: rtl/apb_request_master_if.sv
// rtl/apb_request_master_if.sv - command, response and APB bundles of the request master
interface apb_request_master_if;
  import apb_request_master_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_write;
  logic [ADDR_W-1:0]   cmd_address;
  logic [DATA_W-1:0]   cmd_wdata;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_error;
  logic                rsp_timeout;
  apb_request_t        apb_request;
  apb_response_t       apb_response;
  logic [CNT_W-1:0]    txn_count;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_wdata, rsp_ready, apb_response,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout, apb_request, txn_count
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_wdata, rsp_ready, apb_response,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout, apb_request, txn_count
  );

endinterface

// File: rtl/apb_request_master.sv
// rtl/apb_request_master.sv - single-outstanding APB master with wait-state timeout
module apb_request_master
  import apb_request_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 clk__enable,
  input  logic                 reset,
  apb_request_master_if.master bus
);

  state_t              r_state;
  state_t              w_state_next;

  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic                r_pwrite;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_error;
  logic                r_rsp_timeout;
  logic [CNT_W-1:0]    r_txn_count;

  logic                w_cmd_fire;
  logic                w_rsp_fire;
  logic                w_pready;
  logic [CNT_W:0]      w_wait_inc;
  logic                w_timeout_hit;
  apb_request_t        w_apb_request;

  assign w_pready   = bus.apb_response.pready;
  assign w_cmd_fire = (r_state == ST_IDLE) && bus.cmd_valid;
  assign w_rsp_fire = (r_state == ST_RESPOND) && bus.rsp_ready;

  // One extra bit so a TIMEOUT_CYCLES of 65535 still compares cleanly.
  assign w_wait_inc    = {1'b0, r_wait_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_timeout_hit = (w_wait_inc == (CNT_W+1)'(TIMEOUT_CYCLES));

  // Next-state decode; pready is tested before the timeout so it wins a tie.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (bus.cmd_valid) w_state_next = ST_SETUP;
      ST_SETUP:   w_state_next = ST_ACCESS;
      ST_ACCESS:  if (w_pready || w_timeout_hit) w_state_next = ST_RESPOND;
      ST_RESPOND: if (bus.rsp_ready) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // State register; reset overrides a low clock enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else if (clk__enable) begin
      r_state <= w_state_next;
    end
  end

  // Request capture, wait counter, response capture and completion count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pwrite      <= 1'b0;
      r_wait_cnt    <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_error   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_txn_count   <= '0;
    end else if (clk__enable) begin
      if (w_cmd_fire) begin
        r_paddr  <= bus.cmd_address;
        r_pwdata <= bus.cmd_wdata;
        r_pwrite <= bus.cmd_write;
      end

      if (r_state == ST_SETUP) begin
        r_wait_cnt <= '0;
      end else if ((r_state == ST_ACCESS) && !w_pready) begin
        r_wait_cnt <= w_wait_inc[CNT_W-1:0];
      end

      if (r_state == ST_ACCESS) begin
        if (w_pready) begin
          r_rsp_rdata   <= r_pwrite ? '0 : bus.apb_response.prdata;
          r_rsp_error   <= bus.apb_response.perr;
          r_rsp_timeout <= 1'b0;
        end else if (w_timeout_hit) begin
          r_rsp_rdata   <= '0;
          r_rsp_error   <= 1'b1;
          r_rsp_timeout <= 1'b1;
        end
      end

      if (w_rsp_fire) begin
        r_txn_count <= r_txn_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // APB request bundle: select/enable come from state decode, fields from capture registers.
  always_comb begin
    w_apb_request         = '0;
    w_apb_request.paddr   = r_paddr;
    w_apb_request.pwdata  = r_pwdata;
    w_apb_request.pwrite  = r_pwrite;
    w_apb_request.psel    = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    w_apb_request.penable = (r_state == ST_ACCESS);
  end

  assign bus.apb_request = w_apb_request;
  assign bus.cmd_ready   = (r_state == ST_IDLE);
  assign bus.rsp_valid   = (r_state == ST_RESPOND);
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_error   = r_rsp_error;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.txn_count   = r_txn_count;

endmodule

// File: tb/tb_apb_request_master.sv
// tb/tb_apb_request_master.sv - table-driven scoreboard bench for apb_request_master
module tb_apb_request_master;
  import apb_request_master_pkg::*;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        perr;
    int          acc;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  logic clk;
  logic clk_en;
  logic reset;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   last_hs;
  logic [15:0] exp_count;
  rsp_t sb_q[$];
  vec_t vecs[8];

  apb_request_master_if bus_if ();

  apb_request_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .clk__enable (clk_en),
    .reset       (reset),
    .bus         (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int   acc;
    int   hs;
    rsp_t exp;
    check("cmd_ready_idle", 32'(bus_if.cmd_ready), 32'd1);
    bus_if.cmd_valid   = 1'b1;
    bus_if.cmd_write   = v.wr;
    bus_if.cmd_address = v.addr;
    bus_if.cmd_wdata   = v.wdata;
    sb_q.push_back('{rdata: v.exp_rdata, err: v.exp_err, to: v.exp_to});
    tick();
    hs      = cyc;
    last_hs = cyc;
    bus_if.cmd_valid   = 1'b0;
    bus_if.cmd_write   = ~v.wr;
    bus_if.cmd_address = ~v.addr;
    bus_if.cmd_wdata   = ~v.wdata;
    check("setup_psel", 32'(bus_if.apb_request.psel), 32'd1);
    check("setup_penable", 32'(bus_if.apb_request.penable), 32'd0);
    check("setup_paddr", bus_if.apb_request.paddr, v.addr);
    check("setup_pwrite", 32'(bus_if.apb_request.pwrite), 32'(v.wr));
    check("setup_pwdata", bus_if.apb_request.pwdata, v.wdata);
    check("setup_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
    tick();
    acc = 0;
    while (bus_if.apb_request.penable === 1'b1 && acc < 16) begin
      acc++;
      check("access_psel", 32'(bus_if.apb_request.psel), 32'd1);
      check("access_paddr", bus_if.apb_request.paddr, v.addr);
      check("access_pwdata", bus_if.apb_request.pwdata, v.wdata);
      bus_if.apb_response.pready = (acc == v.waits + 1);
      bus_if.apb_response.prdata = v.prdata;
      bus_if.apb_response.perr   = v.perr;
      tick();
    end
    bus_if.apb_response.pready = 1'b0;
    bus_if.apb_response.perr   = 1'b0;
    bus_if.apb_response.prdata = $urandom;
    check("access_cycles", 32'(acc), 32'(v.acc));
    check("rsp_latency", 32'(cyc - hs), 32'(v.acc + 1));
    check("respond_psel", 32'(bus_if.apb_request.psel), 32'd0);
    check("respond_penable", 32'(bus_if.apb_request.penable), 32'd0);
    check("rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
    check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    for (int h = 0; h < v.hold; h++) begin
      check("hold_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
      check("hold_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
      check("hold_rsp_rdata", bus_if.rsp_rdata, exp.rdata);
      check("hold_rsp_error", 32'(bus_if.rsp_error), 32'(exp.err));
      tick();
    end
    check("rsp_rdata", bus_if.rsp_rdata, exp.rdata);
    check("rsp_error", 32'(bus_if.rsp_error), 32'(exp.err));
    check("rsp_timeout", 32'(bus_if.rsp_timeout), 32'(exp.to));
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    check("post_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("txn_count", 32'(bus_if.txn_count), 32'(exp_count));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    last_hs   = 0;
    exp_count = 16'd0;

    //            wr    addr           wdata          waits prdata         perr acc hold exp_rdata      err   to
    vecs[0] = '{1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 0,  32'h0000_0000, 1'b0, 1, 0,  32'h0000_0000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0000, 32'h1111_2222, 3,  32'h1234_5678, 1'b0, 4, 10, 32'h1234_5678, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 0,  32'hA5A5_0001, 1'b1, 1, 2,  32'hA5A5_0001, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 99, 32'hCAFE_CAFE, 1'b0, 4, 0,  32'h0000_0000, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 32'h0000_0044, 32'h0F0F_0F0F, 3,  32'hFFFF_FFFF, 1'b0, 4, 0,  32'h0000_0000, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_0048, 32'h5555_AAAA, 1,  32'h7777_7777, 1'b1, 2, 0,  32'h0000_0000, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 32'hFFFF_FFFC, 32'h8000_0001, 99, 32'h1234_0000, 1'b1, 4, 1,  32'h0000_0000, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 2,  32'h0BAD_F00D, 1'b0, 3, 0,  32'h0BAD_F00D, 1'b0, 1'b0};

    clk_en             = 1'b1;
    reset              = 1'b1;
    bus_if.cmd_valid   = 1'b1;
    bus_if.cmd_write   = 1'b1;
    bus_if.cmd_address = 32'h1234_5678;
    bus_if.cmd_wdata   = 32'h9ABC_DEF0;
    bus_if.rsp_ready   = 1'b0;
    bus_if.apb_response = '0;
    repeat (3) tick();
    check("rst_psel", 32'(bus_if.apb_request.psel), 32'd0);
    check("rst_penable", 32'(bus_if.apb_request.penable), 32'd0);
    check("rst_pwrite", 32'(bus_if.apb_request.pwrite), 32'd0);
    check("rst_paddr", bus_if.apb_request.paddr, 32'd0);
    check("rst_pwdata", bus_if.apb_request.pwdata, 32'd0);
    check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("rst_rsp_error", 32'(bus_if.rsp_error), 32'd0);
    check("rst_rsp_timeout", 32'(bus_if.rsp_timeout), 32'd0);
    check("rst_rsp_rdata", bus_if.rsp_rdata, 32'd0);
    check("rst_txn_count", 32'(bus_if.txn_count), 32'd0);
    check("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    bus_if.cmd_valid = 1'b0;
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i]);
    end

    // Clock enable low: a pending command and a ready target are both ignored.
    bus_if.cmd_valid   = 1'b1;
    bus_if.cmd_write   = 1'b0;
    bus_if.cmd_address = 32'h0000_0080;
    bus_if.cmd_wdata   = 32'h0;
    clk_en = 1'b0;
    repeat (3) tick();
    check("ce_idle_psel", 32'(bus_if.apb_request.psel), 32'd0);
    check("ce_idle_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    clk_en = 1'b1;
    tick();
    bus_if.cmd_valid = 1'b0;
    check("ce_setup_psel", 32'(bus_if.apb_request.psel), 32'd1);
    tick();
    bus_if.apb_response.pready = 1'b1;
    bus_if.apb_response.prdata = 32'h0C0F_FEE0;
    clk_en = 1'b0;
    repeat (2) tick();
    check("ce_access_penable", 32'(bus_if.apb_request.penable), 32'd1);
    check("ce_access_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    clk_en = 1'b1;
    tick();
    bus_if.apb_response.pready = 1'b0;
    check("ce_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
    check("ce_rsp_rdata", bus_if.rsp_rdata, 32'h0C0F_FEE0);
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    check("ce_txn_count", 32'(bus_if.txn_count), 32'(exp_count));

    // Reset pulsed in ACCESS, with clock enable low, abandons the transaction.
    bus_if.cmd_valid   = 1'b1;
    bus_if.cmd_write   = 1'b0;
    bus_if.cmd_address = 32'h0000_0100;
    tick();
    bus_if.cmd_valid = 1'b0;
    tick();
    tick();
    check("mid_penable", 32'(bus_if.apb_request.penable), 32'd1);
    clk_en = 1'b0;
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
    clk_en = 1'b1;
    exp_count = 16'd0;
    check("mid_rst_psel", 32'(bus_if.apb_request.psel), 32'd0);
    check("mid_rst_penable", 32'(bus_if.apb_request.penable), 32'd0);
    check("mid_rst_paddr", bus_if.apb_request.paddr, 32'd0);
    check("mid_rst_txn_count", 32'(bus_if.txn_count), 32'd0);
    for (int k = 0; k < 5; k++) begin
      check("mid_rst_no_rsp", 32'(bus_if.rsp_valid), 32'd0);
      tick();
    end

    // Counter wrap: preload near the top, then back-to-back minimum-spacing commands.
    force dut.r_txn_count = 16'hFFFD;
    tick();
    release dut.r_txn_count;
    tick();
    exp_count = 16'hFFFD;
    check("preload_txn_count", 32'(bus_if.txn_count), 32'h0000_FFFD);
    run_txn(vecs[0]);
    for (int j = 0; j < 2; j++) begin
      prev = last_hs;
      run_txn(vecs[0]);
      check("cmd_spacing", 32'(last_hs - prev), 32'd4);
    end
    check("wrap_txn_count", 32'(bus_if.txn_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
